data_mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of `data_mem`. It shares the single byte-addressed data memory between the CPU load/store port (m0) and a loader/debug port (m1). It grants one requester at a time with round-robin fairness and drives the memory's MemWrite/MemRead encodings from a registered command, so memory inputs are stable for a full cycle. It returns read data and a one-cycle completion pulse to the winner.

---
 rtl/data_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter/sequencer sharing data_mem between m0 and m1; MEM_ARB_ALIGN_CHECK_EN enables alignment/range rejection.
// Latency: req sampled at E0 -> ACCESS E0..E1 -> done/err pulse and rdata valid in cycle E1..E2.
// Backpressure: requester holds req with stable fields until done; the loser simply waits, one access per 2 cycles.
module data_mem_arbiter #(
   parameter int MEM_BYTES = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [1:0]  m0_we,
   input  logic [2:0]  m0_re,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic [1:0]  m1_we,
   input  logic [2:0]  m1_re,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] rdata,
   output logic [1:0]  mem_MemWrite,
   output logic [2:0]  mem_MemRead,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_MemRead_data
);

`ifdef MEM_ARB_ALIGN_CHECK_EN
   localparam logic CHECK_EN = 1'b1;
`else
   localparam logic CHECK_EN = 1'b0;
`endif

   typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

   state_t      r_state;
   logic        r_last;
   logic        r_id;
   logic        r_bad;
   logic [1:0]  r_gnt;
   logic [1:0]  r_done;
   logic [1:0]  r_err;
   logic [1:0]  r_mem_we;
   logic [2:0]  r_mem_re;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;

   logic        w_any_req;
   logic        w_win;
   logic [1:0]  w_sel_we;
   logic [2:0]  w_sel_re;
   logic [2:0]  w_re_eff;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic [1:0]  w_size;
   logic [2:0]  w_nbytes;
   logic [32:0] w_end;
   logic        w_misalign;
   logic        w_oob;
   logic        w_bad;

   // Tie goes to the port that did not win last time.
   assign w_any_req   = m0_req | m1_req;
   assign w_win       = (m0_req & m1_req) ? ~r_last : m1_req;
   assign w_sel_we    = w_win ? m1_we    : m0_we;
   assign w_sel_re    = w_win ? m1_re    : m0_re;
   assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
   assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

   // A write suppresses any simultaneous read request.
   assign w_re_eff = (w_sel_we != 2'b00) ? 3'b000 : w_sel_re;
   assign w_size   = (w_sel_we != 2'b00) ? w_sel_we : w_sel_re[1:0];

   always_comb begin
      w_nbytes = 3'd0;
      case (w_size)
         2'b01:   w_nbytes = 3'd4;
         2'b10:   w_nbytes = 3'd2;
         2'b11:   w_nbytes = 3'd1;
         default: w_nbytes = 3'd0;
      endcase
   end

   assign w_misalign = ((w_size == 2'b01) && (w_sel_addr[1:0] != 2'b00)) ||
                       ((w_size == 2'b10) && w_sel_addr[0]);
   assign w_end      = {1'b0, w_sel_addr} + {30'd0, w_nbytes};
   assign w_oob      = (w_size != 2'b00) && (w_end > 33'(MEM_BYTES));
   assign w_bad      = CHECK_EN & (w_misalign | w_oob);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_last      <= 1'b1;
         r_id        <= 1'b0;
         r_bad       <= 1'b0;
         r_gnt       <= 2'b00;
         r_done      <= 2'b00;
         r_err       <= 2'b00;
         r_mem_we    <= 2'b00;
         r_mem_re    <= 3'b000;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_rdata     <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 2'b00;
               r_err  <= 2'b00;
               if (w_any_req) begin
                  r_state <= ST_ACCESS;
                  r_last  <= w_win;
                  r_id    <= w_win;
                  r_bad   <= w_bad;
                  r_gnt   <= w_win ? 2'b10 : 2'b01;
                  // A rejected command leaves the memory bus idle for its ACCESS cycle.
                  if (w_bad) begin
                     r_mem_we    <= 2'b00;
                     r_mem_re    <= 3'b000;
                     r_mem_addr  <= 32'd0;
                     r_mem_wdata <= 32'd0;
                  end else begin
                     r_mem_we    <= w_sel_we;
                     r_mem_re    <= w_re_eff;
                     r_mem_addr  <= w_sel_addr;
                     r_mem_wdata <= w_sel_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               r_state     <= ST_IDLE;
               r_gnt       <= 2'b00;
               r_done      <= r_id ? 2'b10 : 2'b01;
               r_err       <= r_bad ? (r_id ? 2'b10 : 2'b01) : 2'b00;
               r_rdata     <= (r_mem_re[1:0] != 2'b00) ? mem_MemRead_data : 32'd0;
               r_mem_we    <= 2'b00;
               r_mem_re    <= 3'b000;
               r_mem_addr  <= 32'd0;
               r_mem_wdata <= 32'd0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign m0_gnt  = r_gnt[0];
   assign m1_gnt  = r_gnt[1];
   assign m0_done = r_done[0];
   assign m1_done = r_done[1];
   assign m0_err  = CHECK_EN & r_err[0];
   assign m1_err  = CHECK_EN & r_err[1];
   assign rdata   = r_rdata;

   // Strobes are gated by reset directly so a reset cycle can never commit a write.
   assign mem_MemWrite   = reset ? r_mem_we : 2'b00;
   assign mem_MemRead    = reset ? r_mem_re : 3'b000;
   assign mem_address    = r_mem_addr;
   assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for data_mem_arbiter with a byte-array data_mem and a byte-level reference model.
module tb_data_mem_arbiter;
   localparam int MB = 128;
`ifdef MEM_ARB_ALIGN_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  we;
      logic [2:0]  re;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req;
   logic [1:0]  m0_we, m1_we;
   logic [2:0]  m0_re, m1_re;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
   logic [31:0] rdata;
   logic [1:0]  mem_MemWrite;
   logic [2:0]  mem_MemRead;
   logic [31:0] mem_address, mem_write_data, mem_rdata;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   model_last = 1'b1;
   bit   watch_noread = 1'b0;
   exp_t exp_q[$];
   bit   gnt_log[$];

   logic [7:0] dmem    [0:MB-1] = '{default: 8'h00};
   logic [7:0] ref_mem [0:MB-1] = '{default: 8'h00};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_arbiter #(.MEM_BYTES(MB)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_re(m0_re), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_re(m1_re), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
      .rdata(rdata),
      .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_MemRead_data(mem_rdata)
   );

   // data_mem stand-in: little-endian bytes, synchronous write, combinational read.
   always @(posedge clk) begin
      int n;
      logic [32:0] ix;
      if (mem_MemWrite != 2'b00) begin
         n = (mem_MemWrite == 2'b01) ? 4 : (mem_MemWrite == 2'b10) ? 2 : 1;
         for (int k = 0; k < n; k++) begin
            ix = {1'b0, mem_address} + 33'(k);
            if (ix < 33'(MB)) dmem[ix[6:0]] <= mem_write_data[8*k +: 8];
         end
      end
   end

   logic [3:0][7:0] rb;
   logic [32:0]     rix;
   always_comb begin
      rb  = '0;
      rix = '0;
      for (int k = 0; k < 4; k++) begin
         rix   = {1'b0, mem_address} + 33'(k);
         rb[k] = (rix < 33'(MB)) ? dmem[rix[6:0]] : 8'h00;
      end
      case (mem_MemRead[1:0])
         2'b01:   mem_rdata = rb;
         2'b10:   mem_rdata = {{16{mem_MemRead[2] & rb[1][7]}}, rb[1], rb[0]};
         2'b11:   mem_rdata = {{24{mem_MemRead[2] & rb[0][7]}}, rb[0]};
         default: mem_rdata = 32'd0;
      endcase
   end

   task automatic model_exec(input cmd_t c, output logic [31:0] rd, output bit err);
      int     sz, nb;
      longint a;
      sz  = (c.we != 2'b00) ? int'(c.we) : int'(c.re[1:0]);
      nb  = (sz == 1) ? 4 : (sz == 2) ? 2 : (sz == 3) ? 1 : 0;
      a   = longint'(c.addr);
      err = CHK_EN && nb != 0 &&
            ((nb == 4 && (a % 4) != 0) || (nb == 2 && (a % 2) != 0) || (a + nb > MB));
      rd  = 32'd0;
      if (err) return;
      if (c.we != 2'b00) begin
         for (int k = 0; k < nb; k++)
            if (a + k < MB) ref_mem[7'(a + k)] = c.wdata[8*k +: 8];
      end else if (nb != 0) begin
         for (int k = 0; k < nb; k++)
            rd[8*k +: 8] = (a + k < MB) ? ref_mem[7'(a + k)] : 8'h00;
         if (c.re[2] && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
      end
   endtask

   task automatic predict(input bit p, input cmd_t c);
      exp_t e;
      e.port = p;
      model_exec(c, e.rdata, e.err);
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit p, input cmd_t c);
      if (p) begin
         m1_we = c.we; m1_re = c.re; m1_addr = c.addr; m1_wdata = c.wdata; m1_req = 1'b1;
      end else begin
         m0_we = c.we; m0_re = c.re; m0_addr = c.addr; m0_wdata = c.wdata; m0_req = 1'b1;
      end
   endtask

   task automatic wait_done(input bit p, input bit chk_lat, input int c0);
      bit seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (p ? m1_done : m0_done) seen = 1'b1;
      end
      if (p) m1_req = 1'b0; else m0_req = 1'b0;
      if (!seen) begin
         tests++; fails++;
         $display("FAIL done_timeout port=%0d: no done within 12 cycles", p);
      end else if (chk_lat) begin
         tests++;
         if (cyc - c0 != 2) begin
            fails++;
            $display("FAIL latency port=%0d: got %0d cycles, need 2", p, cyc - c0);
         end
      end
   endtask

   task automatic issue(input bit u0, input bit u1, input cmd_t c0, input cmd_t c1);
      int start;
      @(posedge clk); #1;
      if (u0 && u1) begin
         if (model_last) begin predict(0, c0); predict(1, c1); model_last = 1'b1; end
         else            begin predict(1, c1); predict(0, c0); model_last = 1'b0; end
      end else if (u0) begin
         predict(0, c0); model_last = 1'b0;
      end else if (u1) begin
         predict(1, c1); model_last = 1'b1;
      end
      if (u0) drive(0, c0);
      if (u1) drive(1, c1);
      start = cyc;
      fork
         begin if (u0) wait_done(0, !(u0 && u1), start); end
         begin if (u1) wait_done(1, !(u0 && u1), start); end
      join
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err} != 6'd0 || rdata != 32'd0 ||
          mem_MemWrite != 2'd0 || mem_MemRead != 3'd0 || mem_address != 32'd0 || mem_write_data != 32'd0) begin
         fails++;
         $display("FAIL reset_state: flags=%b rdata=%h we=%b re=%b addr=%h wd=%h, need all zero",
                  {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err}, rdata, mem_MemWrite, mem_MemRead,
                  mem_address, mem_write_data);
      end
      reset = 1'b1;
      model_last = 1'b1;
   endtask

   // Monitor: protocol invariants each cycle, scoreboard pop on every completion.
   always @(negedge clk) begin
      exp_t e;
      bit   p;
      if (m0_gnt) gnt_log.push_back(1'b0);
      if (m1_gnt) gnt_log.push_back(1'b1);
      if (m0_gnt | m1_gnt | m0_done | m1_done) begin
         tests++;
         if ((m0_gnt && m1_gnt) || (m0_done && m1_done) || (m0_gnt && m0_done) || (m1_gnt && m1_done)) begin
            fails++;
            $display("FAIL exclusive: gnt=%b%b done=%b%b", m1_gnt, m0_gnt, m1_done, m0_done);
         end
      end else begin
         tests++;
         if (mem_MemWrite != 2'd0 || mem_MemRead != 3'd0 || mem_address != 32'd0 || mem_write_data != 32'd0) begin
            fails++;
            $display("FAIL idle_bus: we=%b re=%b addr=%h wd=%h, need zero", mem_MemWrite, mem_MemRead,
                     mem_address, mem_write_data);
         end
      end
      if (watch_noread) begin
         tests++;
         if (mem_MemRead != 3'd0) begin
            fails++;
            $display("FAIL rejected_read: MemRead=%b, need 000", mem_MemRead);
         end
      end
      if (m0_done || m1_done) begin
         tests++;
         p = m1_done;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: port=%0d rdata=%h, none expected", p, rdata);
         end else begin
            e = exp_q.pop_front();
            if (e.port != p || e.rdata != rdata || e.err != (p ? m1_err : m0_err)) begin
               fails++;
               $display("FAIL completion: port=%0d rdata=%h err=%0d, need port=%0d rdata=%h err=%0d",
                        p, rdata, p ? m1_err : m0_err, e.port, e.rdata, e.err);
            end
         end
      end
   end

   initial begin
      cmd_t c0, c1, nop;
      int   n, u;
      logic [3:0] g;
      nop = '0;
      reset = 1'b0;
      m0_req = 1'b0; m0_we = '0; m0_re = '0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = '0; m1_re = '0; m1_addr = '0; m1_wdata = '0;
      reset_dut();

      // Word write then read back.
      c0 = '{we: 2'b01, re: 3'b000, addr: 32'h10, wdata: 32'hDEAD_BEEF};
      issue(1, 0, c0, nop);
      c0 = '{we: 2'b00, re: 3'b001, addr: 32'h10, wdata: 32'h0};
      issue(1, 0, c0, nop);
      repeat (3) @(negedge clk);
      tests++;
      if (rdata != 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL rdata_hold: got %h, need deadbeef", rdata);
      end

      // Byte store and signed/unsigned byte loads.
      c0 = '{we: 2'b11, re: 3'b000, addr: 32'h21, wdata: 32'h0000_0080};
      issue(1, 0, c0, nop);
      c0 = '{we: 2'b00, re: 3'b111, addr: 32'h21, wdata: 32'h0};
      issue(1, 0, c0, nop);
      c0.re = 3'b011;
      issue(1, 0, c0, nop);
      // we and re together, and a no-op.
      c0 = '{we: 2'b10, re: 3'b001, addr: 32'h30, wdata: 32'h1234_ABCD};
      issue(1, 0, c0, nop);
      issue(0, 1, nop, nop);

      // Both ports hold req continuously across 4 transactions.
      reset_dut();
      @(posedge clk); #1;
      gnt_log.delete();
      c0 = '{we: 2'b00, re: 3'b001, addr: 32'h10, wdata: 32'h0};
      c1 = '{we: 2'b00, re: 3'b111, addr: 32'h21, wdata: 32'h0};
      predict(0, c0); predict(1, c1); predict(0, c0); predict(1, c1);
      model_last = 1'b1;
      drive(0, c0); drive(1, c1);
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (m0_done || m1_done) n++;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      tests++;
      g = 4'b0;
      for (int i = 0; i < 4 && i < gnt_log.size(); i++) g[i] = gnt_log[i];
      if (n != 4 || gnt_log.size() != 4 || g != 4'b1010) begin
         fails++;
         $display("FAIL rr_order: dones=%0d grants=%0d seq(lsb first)=%b, need 4/4/1010", n, gnt_log.size(), g);
      end

      // Reset in the middle of an m1 write: no done, no commit.
      c1 = '{we: 2'b11, re: 3'b000, addr: 32'h05, wdata: 32'h11};
      issue(0, 1, nop, c1);
      c1 = '{we: 2'b00, re: 3'b111, addr: 32'h21, wdata: 32'h0};
      issue(0, 1, nop, c1);
      @(posedge clk); #1;
      drive(1, '{we: 2'b11, re: 3'b000, addr: 32'h05, wdata: 32'h55});
      @(posedge clk); #1;
      tests++;
      if (m1_gnt != 1'b1) begin
         fails++;
         $display("FAIL abort_gnt: m1_gnt=%b, need 1", m1_gnt);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      m1_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_last = 1'b1;
      tests++;
      if (rdata != 32'd0) begin
         fails++;
         $display("FAIL reset_rdata: got %h, need 0", rdata);
      end
      repeat (3) @(posedge clk);
      c1 = '{we: 2'b00, re: 3'b011, addr: 32'h05, wdata: 32'h0};
      issue(0, 1, nop, c1);

      // Word read straddling the top of memory.
      watch_noread = CHK_EN;
      c0 = '{we: 2'b00, re: 3'b001, addr: 32'h7E, wdata: 32'h0};
      issue(1, 0, c0, nop);
      watch_noread = 1'b0;

      // Randomized mix of single and contending requests.
      for (int it = 0; it < 80; it++) begin
         u = int'($urandom_range(1, 3));
         c0.addr  = 32'($urandom_range(0, MB - 1));
         c0.we    = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(0, 3));
         c0.re    = 3'($urandom_range(0, 7));
         c0.wdata = $urandom;
         c1.addr  = 32'($urandom_range(0, MB - 1));
         c1.we    = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(0, 3));
         c1.re    = 3'($urandom_range(0, 7));
         c1.wdata = $urandom;
         issue(u[0], u[1], c0, c1);
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain: %0d completions outstanding, need 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
